// File: rtl/moving_board.sv
// Vertically travelling board sprite: moves between Y_HOME and Y_AWAY one frame at a time, decodes pixel hits into a ROM address.
// Latency: position/flags update one Clk after a frame_clk rising edge; is_board/board_address are combinational from DrawX/DrawY.
// No backpressure; optional signed per-frame displacement output when BOARD_DY_EN is defined.
module moving_board #(
    parameter int X0     = 556,
    parameter int Y_HOME = 204,
    parameter int Y_AWAY = 252,
    parameter int W      = 68,
    parameter int H      = 12,
    parameter int STEP   = 1,
    parameter int AW     = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_clk,
    input  logic          activate,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    output logic          is_board,
    output logic [AW-1:0] board_address,
    output logic [9:0]    board_y,
    output logic          at_home,
    output logic          at_away
`ifdef BOARD_DY_EN
    ,
    output logic signed [9:0] board_dy
`endif
);

    typedef enum logic [1:0] {
        HOME    = 2'd0,
        TO_AWAY = 2'd1,
        AWAY    = 2'd2,
        TO_HOME = 2'd3
    } state_t;

    localparam logic        [11:0] L_X0   = 12'(X0);
    localparam logic        [11:0] L_XE   = 12'(X0 + W);
    localparam logic        [11:0] L_H    = 12'(H);
    localparam logic signed [11:0] L_YH   = 12'(Y_HOME);
    localparam logic signed [11:0] L_YA   = 12'(Y_AWAY);
    localparam logic signed [11:0] L_STEP = 12'(STEP);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_y;
    logic [9:0]  w_y_nxt;
    logic        r_fclk_d;
    logic        r_at_home;
    logic        r_at_away;
    logic        w_tick;
    logic        w_move;

    logic signed [11:0] w_cur;
    logic signed [11:0] w_tgt;
    logic signed [11:0] w_diff;
    logic signed [11:0] w_dist;
    logic signed [11:0] w_mv;
    logic signed [11:0] w_y_new;

    assign w_tick = frame_clk & ~r_fclk_d;

    // Candidate position: one clamped step toward whichever end activate asks for.
    always_comb begin
        w_cur   = $signed({2'b00, r_y});
        w_tgt   = activate ? L_YA : L_YH;
        w_diff  = w_tgt - w_cur;
        w_dist  = w_diff[11] ? -w_diff : w_diff;
        w_mv    = (w_dist < L_STEP) ? w_dist : L_STEP;
        w_y_new = w_diff[11] ? (w_cur - w_mv) : (w_cur + w_mv);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_move      = 1'b0;
        if (w_tick) begin
            case (r_state)
                HOME:             w_move = activate;
                AWAY:             w_move = ~activate;
                TO_AWAY, TO_HOME: w_move = 1'b1;
                default:          w_move = 1'b0;
            endcase
        end
        if (w_move) begin
            w_y_nxt = w_y_new[9:0];
            if (w_y_new == w_tgt) begin
                w_state_nxt = activate ? AWAY : HOME;
            end else begin
                w_state_nxt = activate ? TO_AWAY : TO_HOME;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= HOME;
            r_y       <= 10'(Y_HOME);
            r_fclk_d  <= 1'b0;
            r_at_home <= 1'b1;
            r_at_away <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_y       <= w_y_nxt;
            r_fclk_d  <= frame_clk;
            r_at_home <= (w_state_nxt == HOME);
            r_at_away <= (w_state_nxt == AWAY);
        end
    end

`ifdef BOARD_DY_EN
    logic signed [9:0] r_dy;

    // Held between ticks so a rider can be carried by the same amount each frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_dy <= '0;
        end else if (w_tick) begin
            r_dy <= 10'($signed({2'b00, w_y_nxt}) - w_cur);
        end
    end

    assign board_dy = r_dy;
`endif

    assign board_y = r_y;
    assign at_home = r_at_home;
    assign at_away = r_at_away;

    logic [11:0] w_px;
    logic [11:0] w_py;
    logic [11:0] w_top;
    logic [11:0] w_bot;
    logic [11:0] w_col;
    logic [11:0] w_row;

    always_comb begin
        w_px  = {2'b00, DrawX};
        w_py  = {2'b00, DrawY};
        w_top = {2'b00, r_y};
        w_bot = w_top + L_H;
        w_col = w_px - L_X0;
        w_row = w_py - w_top;
    end

    assign is_board = (w_px >= L_X0) && (w_px < L_XE) && (w_py >= w_top) && (w_py < w_bot);

    assign board_address = is_board
                         ? AW'({12'd0, w_col} + ({12'd0, w_row} * 24'(W)))
                         : '0;

endmodule

// File: tb/tb_moving_board.sv
// Bench for moving_board: three parameterisations driven in parallel against a position-level reference model.
module tb_moving_board;

    localparam int YH = 204;
    localparam int YA [3] = '{252, 252, 100};
    localparam int ST [3] = '{1, 5, 3};

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       activate;
    logic [9:0] DrawX;
    logic [9:0] DrawY;

    logic       is_b [3];
    logic [9:0] adr  [3];
    logic [9:0] by   [3];
    logic       ah   [3];
    logic       aa   [3];
`ifdef BOARD_DY_EN
    logic signed [9:0] bdy [3];
`endif

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        moving_board #(
            .Y_AWAY (YA[g]),
            .STEP   (ST[g])
        ) u_dut (
            .Clk           (Clk),
            .Reset         (Reset),
            .frame_clk     (frame_clk),
            .activate      (activate),
            .DrawX         (DrawX),
            .DrawY         (DrawY),
            .is_board      (is_b[g]),
            .board_address (adr[g]),
            .board_y       (by[g]),
`ifdef BOARD_DY_EN
            .board_dy      (bdy[g]),
`endif
            .at_home       (ah[g]),
            .at_away       (aa[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    int m_y  [3];
    int m_dy [3];
    bit m_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic int next_y(input int y, input int t, input int s);
        int d;
        d = t - y;
        if (d > s)  return y + s;
        if (d < -s) return y - s;
        return t;
    endfunction

    // One Clk cycle: apply inputs, advance the model, check registered outputs after the edge.
    task automatic step(input logic rst, input logic fc, input logic act);
        int nm;
        Reset     = rst;
        frame_clk = fc;
        activate  = act;
        if (rst) begin
            m_prev = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_y[i]  = YH;
                m_dy[i] = 0;
            end
        end else begin
            if (fc && !m_prev) begin
                for (int i = 0; i < 3; i++) begin
                    nm      = next_y(m_y[i], act ? YA[i] : YH, ST[i]);
                    m_dy[i] = nm - m_y[i];
                    m_y[i]  = nm;
                end
            end
            m_prev = fc;
        end
        @(posedge Clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("board_y[%0d]", i), 32'(by[i]), m_y[i]);
            check($sformatf("at_home[%0d]", i), 32'(ah[i]), 32'(m_y[i] == YH));
            check($sformatf("at_away[%0d]", i), 32'(aa[i]), 32'(m_y[i] == YA[i]));
`ifdef BOARD_DY_EN
            check($sformatf("board_dy[%0d]", i), 32'(bdy[i]), m_dy[i]);
`endif
        end
    endtask

    task automatic tick_pulse(input logic act);
        step(1'b0, 1'b1, act);
        step(1'b0, 1'b0, act);
    endtask

    task automatic check_pixels(input logic [9:0] x, input logic [9:0] y);
        bit inb;
        int a;
        DrawX = x;
        DrawY = y;
        #1;
        for (int i = 0; i < 3; i++) begin
            inb = (int'(x) >= 556) && (int'(x) < 556 + 68) && (int'(y) >= m_y[i]) && (int'(y) < m_y[i] + 12);
            a   = inb ? (((int'(x) - 556) + (int'(y) - m_y[i]) * 68) % 1024) : 0;
            check($sformatf("is_board[%0d]", i), 32'(is_b[i]), 32'(inb));
            check($sformatf("address[%0d]", i), 32'(adr[i]), a);
        end
    endtask

    initial begin
        logic fc;
        logic act;
        Reset     = 1'b1;
        frame_clk = 1'b0;
        activate  = 1'b0;
        DrawX     = '0;
        DrawY     = '0;
        #1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Full travel to AWAY with unit and 5-pixel steps.
        for (int k = 1; k <= 48; k++) begin
            tick_pulse(1'b1);
            if (k == 9)  check("step5_tick9_y", 32'(by[1]), 249);
            if (k == 10) check("step5_tick10_y", 32'(by[1]), 252);
            if (k == 10) check("step5_tick10_away", 32'(aa[1]), 1);
            if (k == 47) check("unit_tick47_away", 32'(aa[0]), 0);
            if (k == 48) check("unit_tick48_y", 32'(by[0]), 252);
            if (k == 48) check("unit_tick48_away", 32'(aa[0]), 1);
        end

        // Reversal mid-travel at 220.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) tick_pulse(1'b1);
        check("rev_pre_y", 32'(by[0]), 220);
        tick_pulse(1'b0);
        check("rev_post_y", 32'(by[0]), 219);
        check("rev_post_home", 32'(ah[0]), 0);
        check("rev_post_away", 32'(aa[0]), 0);
`ifdef BOARD_DY_EN
        check("rev_post_dy", 32'(bdy[0]), -1);
`endif

        // Pixel decode while parked at home.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        DrawX = 10'd556; DrawY = 10'd204; #1;
        check("pix_corner_in", 32'(is_b[0]), 1);
        check("pix_corner_addr", 32'(adr[0]), 0);
        DrawX = 10'd623; DrawY = 10'd215; #1;
        check("pix_last_addr", 32'(adr[0]), 815);
        DrawX = 10'd624; #1;
        check("pix_right_out", 32'(is_b[0]), 0);
        check("pix_right_addr", 32'(adr[0]), 0);

        // Reset coincident with a frame tick mid-travel.
        for (int k = 0; k < 26; k++) tick_pulse(1'b1);
        check("rst_pre_y", 32'(by[0]), 230);
        step(1'b1, 1'b1, 1'b1);
        check("rst_tick_y", 32'(by[0]), 204);
        check("rst_tick_home", 32'(ah[0]), 1);
        step(1'b0, 1'b0, 1'b0);

        // frame_clk held high: a single move only.
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b1);
        check("held_high_y", 32'(by[0]), 205);
        step(1'b0, 1'b0, 1'b1);

        // Randomised frames, lever changes, occasional reset and pixel probes.
        fc  = 1'b0;
        act = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) fc = ~fc;
            if ($urandom_range(0, 40) == 0) act = ~act;
            step(($urandom_range(0, 600) == 0) ? 1'b1 : 1'b0, fc, act);
            if ((c % 4) == 0) begin
                check_pixels(10'($urandom_range(545, 635)), 10'($urandom_range(90, 270)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/moving_board.md
MOVING_BOARD -- requirements
Module: moving_board

Interface
REQ-001 Parameter X0, default 556, left pixel column of the board, fixed.
REQ-002 Parameter Y_HOME, default 204, top pixel row of the board at rest.
REQ-003 Parameter Y_AWAY, default 252, top pixel row of the board when fully moved; SHALL differ from Y_HOME and may be above or below it.
REQ-004 Parameter W, default 68, board width in pixels; parameter H, default 12, board height in pixels.
REQ-005 Parameter STEP, default 1, maximum pixels moved per frame; SHALL be at least 1.
REQ-006 Parameter AW, default 10, address width; W*H SHALL be at most 2**AW.
REQ-007 Port Clk, input, 1, system clock; one clock domain only.
REQ-008 Port Reset, input, 1, synchronous active-high reset.
REQ-009 Port frame_clk, input, 1, VGA vsync-rate strobe, sampled on Clk.
REQ-010 Port activate, input, 1, lever/button level; 1 requests AWAY, 0 requests HOME.
REQ-011 Port DrawX, DrawY, input, 10 each, current pixel coordinates.
REQ-012 Port is_board, output, 1, current pixel lies inside the board.
REQ-013 Port board_address, output, AW, ROM index of the current pixel.
REQ-014 Port board_y, output, 10, registered current top row.
REQ-015 Port at_home, at_away, output, 1 each, registered; board is parked at that end.
REQ-016 Port board_dy, output, signed 10, signed displacement applied at the last frame tick; present only under BOARD_DY_EN.

Function
REQ-017 frame_tick SHALL be a one-Clk pulse on each rising edge of frame_clk, detected with a registered copy of frame_clk; all motion SHALL update only on frame_tick.
REQ-018 FSM states: HOME, TO_AWAY, AWAY, TO_HOME.
REQ-019 Transitions are evaluated on frame_tick only: HOME to TO_AWAY if activate=1; AWAY to TO_HOME if activate=0; TO_AWAY to TO_HOME if activate=0; TO_HOME to TO_AWAY if activate=1.
REQ-020 In TO_AWAY and TO_HOME, each frame_tick moves board_y toward the target by min(STEP, |target-board_y|), so the board never overshoots.
REQ-021 When board_y equals the target after a move, the FSM enters AWAY or HOME in that same update.
REQ-022 A direction reversal mid-travel takes effect on the same tick and moves one step toward the new target from the current position.
REQ-023 at_home SHALL equal (state==HOME); at_away SHALL equal (state==AWAY).
REQ-024 is_board SHALL equal 1 if X0 <= DrawX < X0+W and board_y <= DrawY < board_y+H, and 0 otherwise; it is combinational from DrawX, DrawY and the board_y register.
REQ-025 Inside the board, board_address = (DrawX-X0) + (DrawY-board_y)*W, truncated to AW bits; outside the board it SHALL be 0.
REQ-026 All arithmetic SHALL be performed at at least 11 bits, so no intermediate wraps for any legal parameter set.

Reset
REQ-027 On Reset: state=HOME, board_y=Y_HOME, at_home=1, at_away=0, board_dy=0, and the frame_clk history register=0.
REQ-028 Reset SHALL override a coincident frame_tick; a reset asserted mid-travel returns the board to Y_HOME in the next cycle.
REQ-029 The first frame_tick after reset is detected only on a 0-to-1 transition sampled after reset is released.

Configuration
REQ-030 Macro BOARD_DY_EN: when defined, board_dy is present; it is registered on frame_tick to the signed change of board_y (0 when parked) and holds between ticks, so a character standing on the board can be carried.
REQ-031 Without BOARD_DY_EN, the board_dy port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then activate=1 with defaults -> board_y steps 204,205,...,252 on successive ticks; at_away=1 on the 48th tick.
REQ-033 STEP=5 -> board_y 204,209,...,249,252 with no overshoot; state=AWAY after the 10th tick.
REQ-034 Drop activate at board_y=220 in TO_AWAY -> next tick board_y=219, state=TO_HOME; board_dy=-1 under BOARD_DY_EN.
REQ-035 Parked at home, DrawX=556, DrawY=204 -> is_board=1, address 0; DrawX=623, DrawY=215 -> address 815; DrawX=624 -> is_board=0, address 0.
REQ-036 Assert Reset at board_y=230 coincident with a frame_tick -> the next cycle shows board_y=204, at_home=1, and no move is applied.
REQ-037 Hold frame_clk high for many cycles -> exactly one move per rising edge.
